// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM handshake state and arbiter FSM types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - CPU-side request/stall bundle and RAM-side port of the arbiter
interface mem_arbiter_rr_if
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) ();

  logic [CPUS-1:0]  iREN;
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] iaddr;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  iwait;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational pick of the first set request at or after ptr, wrapping modulo N
module rr_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter of per-CPU instruction/data ports onto one RAM
module mem_arbiter_rr
  import cpu_types_pkg::*;
#(
  parameter int CPUS       = 2,
  parameter bit DATA_FIRST = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  mem_arbiter_rr_if.slave bus
);

  localparam int N  = 2 * CPUS;
  localparam int IW = $clog2(N);

  arb_state_t    state, state_next;
  logic [IW-1:0] rr_ptr, rr_ptr_next;
  logic [IW-1:0] winner, winner_next;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [N-1:0]  act, data_mask, elig;
  logic          win_active;

  // Requester k = 2*cpu is the data port, 2*cpu+1 the instruction port.
  always_comb begin
    act       = '0;
    data_mask = '0;
    for (int c = 0; c < CPUS; c++) begin
      act[2*c]       = bus.dREN[c] | bus.dWEN[c];
      act[2*c+1]     = bus.iREN[c];
      data_mask[2*c] = 1'b1;
    end
  end

  assign elig = (DATA_FIRST && |(act & data_mask)) ? (act & data_mask) : act;

  rr_picker #(.N(N)) u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (pick),
    .valid (pick_valid)
  );

  assign bus.iload = {CPUS{bus.ramload}};
  assign bus.dload = {CPUS{bus.ramload}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      winner <= winner_next;
    end
  end

  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    winner_next  = winner;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramerr   = 1'b0;
    bus.iwait    = '1;
    bus.dwait    = '1;
    win_active   = act[winner];

    case (state)
      IDLE: begin
        if (pick_valid) begin
          winner_next = pick;
          state_next  = XFER;
        end
      end
      XFER: begin
        if (!win_active) begin
          state_next = IDLE;
        end else begin
          for (int c = 0; c < CPUS; c++) begin
            if (winner == IW'(2*c)) begin
              bus.ramWEN   = bus.dWEN[c];
              bus.ramREN   = ~bus.dWEN[c];
              bus.ramaddr  = bus.daddr[c];
              bus.ramstore = bus.dstore[c];
            end else if (winner == IW'(2*c+1)) begin
              bus.ramREN  = 1'b1;
              bus.ramaddr = bus.iaddr[c];
            end
          end
          if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            for (int c = 0; c < CPUS; c++) begin
              if (winner == IW'(2*c))   bus.dwait[c] = 1'b0;
              if (winner == IW'(2*c+1)) bus.iwait[c] = 1'b0;
            end
            rr_ptr_next = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
            bus.ramerr  = (bus.ramstate == ERROR);
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - directed bench for mem_arbiter_rr with data-first and pure round-robin instances
module tb_mem_arbiter_rr;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  iREN, dREN, dWEN;
  word_t [1:0] iaddr, daddr, dstore;
  word_t       ramload;
  ramstate_t   ramstate;

  mem_arbiter_rr_if #(.CPUS(2)) if_df ();
  mem_arbiter_rr_if #(.CPUS(2)) if_rr ();

  assign if_df.iREN = iREN;     assign if_rr.iREN = iREN;
  assign if_df.dREN = dREN;     assign if_rr.dREN = dREN;
  assign if_df.dWEN = dWEN;     assign if_rr.dWEN = dWEN;
  assign if_df.iaddr = iaddr;   assign if_rr.iaddr = iaddr;
  assign if_df.daddr = daddr;   assign if_rr.daddr = daddr;
  assign if_df.dstore = dstore; assign if_rr.dstore = dstore;
  assign if_df.ramload = ramload;   assign if_rr.ramload = ramload;
  assign if_df.ramstate = ramstate; assign if_rr.ramstate = ramstate;

  mem_arbiter_rr #(.CPUS(2), .DATA_FIRST(1'b1)) dut_df (.CLK(CLK), .RST(RST), .bus(if_df));
  mem_arbiter_rr #(.CPUS(2), .DATA_FIRST(1'b0)) dut_rr (.CLK(CLK), .RST(RST), .bus(if_rr));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    iREN = 2'b11; dWEN = 2'b11; ramstate = ERROR;
    tick();
    checks++; if (if_df.ramREN !== 1'b0) begin failures++; $display("FAIL reset_ramREN got=%b exp=0", if_df.ramREN); end
    checks++; if (if_df.ramWEN !== 1'b0) begin failures++; $display("FAIL reset_ramWEN got=%b exp=0", if_df.ramWEN); end
    checks++; if (if_df.ramaddr !== 32'h0) begin failures++; $display("FAIL reset_ramaddr got=%h exp=0", if_df.ramaddr); end
    checks++; if (if_df.ramstore !== 32'h0) begin failures++; $display("FAIL reset_ramstore got=%h exp=0", if_df.ramstore); end
    checks++; if ({if_df.iwait, if_df.dwait} !== 4'b1111) begin failures++; $display("FAIL reset_waits got=%b exp=1111", {if_df.iwait, if_df.dwait}); end
    checks++; if (if_df.ramerr !== 1'b0) begin failures++; $display("FAIL reset_ramerr got=%b exp=0", if_df.ramerr); end
    tick();
    checks++; if (if_rr.ramREN !== 1'b0) begin failures++; $display("FAIL reset_rr_ramREN got=%b exp=0", if_rr.ramREN); end
    clear_inputs();
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h100; ramload = 32'h1234_5678;
    #1;
    checks++; if (if_rr.ramREN !== 1'b0 || if_rr.iwait !== 2'b11) begin failures++; $display("FAIL single_arb ramREN=%b iwait=%b exp 0/11", if_rr.ramREN, if_rr.iwait); end
    tick();
    ramstate = BUSY;
    #1;
    checks++; if (if_rr.ramREN !== 1'b1 || if_rr.ramaddr !== 32'h100) begin failures++; $display("FAIL single_busy ramREN=%b addr=%h exp 1/100", if_rr.ramREN, if_rr.ramaddr); end
    checks++; if (if_rr.iwait !== 2'b11) begin failures++; $display("FAIL single_busy_wait got=%b exp=11", if_rr.iwait); end
    tick();
    ramstate = ACCESS;
    #1;
    checks++; if (if_rr.iwait !== 2'b10 || if_rr.dwait !== 2'b11) begin failures++; $display("FAIL single_access_wait i=%b d=%b exp 10/11", if_rr.iwait, if_rr.dwait); end
    checks++; if (if_rr.ramREN !== 1'b1 || if_rr.ramaddr !== 32'h100) begin failures++; $display("FAIL single_access ramREN=%b addr=%h exp 1/100", if_rr.ramREN, if_rr.ramaddr); end
    checks++; if (if_rr.iload[0] !== 32'h1234_5678 || if_rr.dload[1] !== 32'h1234_5678) begin failures++; $display("FAIL single_load i0=%h d1=%h exp 12345678", if_rr.iload[0], if_rr.dload[1]); end
    tick();
    iREN = 2'b00; ramstate = FREE;
    #1;
    checks++; if (if_rr.iwait !== 2'b11 || if_rr.ramREN !== 1'b0) begin failures++; $display("FAIL single_after iwait=%b ramREN=%b exp 11/0", if_rr.iwait, if_rr.ramREN); end
  endtask

  task automatic test_data_first();
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h100;
    dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hDEAD_BEEF;
    #1;
    checks++; if (if_df.ramWEN !== 1'b0) begin failures++; $display("FAIL df_arb ramWEN got=%b exp=0", if_df.ramWEN); end
    tick();
    ramstate = ACCESS;
    #1;
    checks++; if (if_df.ramWEN !== 1'b1 || if_df.ramREN !== 1'b0) begin failures++; $display("FAIL df_write_en WEN=%b REN=%b exp 1/0", if_df.ramWEN, if_df.ramREN); end
    checks++; if (if_df.ramaddr !== 32'h200 || if_df.ramstore !== 32'hDEAD_BEEF) begin failures++; $display("FAIL df_write addr=%h store=%h exp 200/deadbeef", if_df.ramaddr, if_df.ramstore); end
    checks++; if (if_df.dwait !== 2'b01 || if_df.iwait !== 2'b11) begin failures++; $display("FAIL df_write_wait d=%b i=%b exp 01/11", if_df.dwait, if_df.iwait); end
    tick();
    dWEN = 2'b00; ramstate = FREE;
    #1;
    checks++; if (if_df.ramREN !== 1'b0) begin failures++; $display("FAIL df_idle ramREN got=%b exp=0", if_df.ramREN); end
    tick();
    ramstate = ACCESS;
    #1;
    checks++; if (if_df.ramREN !== 1'b1 || if_df.ramaddr !== 32'h100 || if_df.iwait !== 2'b10) begin failures++; $display("FAIL df_instr REN=%b addr=%h iwait=%b exp 1/100/10", if_df.ramREN, if_df.ramaddr, if_df.iwait); end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    word_t exp_addr [4];
    int    order [5];
    int    k;
    logic [1:0] exp_i, exp_d;
    exp_addr = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
    order    = '{0, 1, 2, 3, 0};
    do_reset();
    dREN = 2'b11; iREN = 2'b11;
    daddr[0] = 32'hA0; iaddr[0] = 32'hB0; daddr[1] = 32'hC0; iaddr[1] = 32'hD0;
    for (int g = 0; g < 5; g++) begin
      k = order[g];
      #1;
      checks++; if (if_rr.ramREN !== 1'b0) begin failures++; $display("FAIL rr_idle_%0d ramREN got=%b exp=0", g, if_rr.ramREN); end
      tick();
      ramstate = BUSY;
      #1;
      checks++; if (if_rr.ramaddr !== exp_addr[k]) begin failures++; $display("FAIL rr_grant_%0d addr got=%h exp=%h", g, if_rr.ramaddr, exp_addr[k]); end
      tick();
      ramstate = ACCESS;
      #1;
      exp_i = 2'b11; exp_d = 2'b11;
      if (k % 2 == 1) exp_i[k/2] = 1'b0;
      else            exp_d[k/2] = 1'b0;
      checks++; if ({if_rr.iwait, if_rr.dwait} !== {exp_i, exp_d}) begin failures++; $display("FAIL rr_wait_%0d got=%b exp=%b", g, {if_rr.iwait, if_rr.dwait}, {exp_i, exp_d}); end
      checks++; if (if_rr.ramWEN !== 1'b0 || if_rr.ramREN !== 1'b1) begin failures++; $display("FAIL rr_en_%0d WEN=%b REN=%b exp 0/1", g, if_rr.ramWEN, if_rr.ramREN); end
      tick();
      ramstate = FREE;
    end
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    dREN = 2'b01; daddr[0] = 32'h300;
    iREN = 2'b01; iaddr[0] = 32'h310;
    tick();
    ramstate = BUSY;
    #1;
    checks++; if (if_rr.ramREN !== 1'b1 || if_rr.ramaddr !== 32'h300) begin failures++; $display("FAIL abort_busy REN=%b addr=%h exp 1/300", if_rr.ramREN, if_rr.ramaddr); end
    tick();
    dREN = 2'b00;
    #1;
    checks++; if (if_rr.ramREN !== 1'b0) begin failures++; $display("FAIL abort_drop ramREN got=%b exp=0", if_rr.ramREN); end
    checks++; if ({if_rr.iwait, if_rr.dwait} !== 4'b1111) begin failures++; $display("FAIL abort_waits got=%b exp=1111", {if_rr.iwait, if_rr.dwait}); end
    tick();
    dREN = 2'b01;
    #1;
    checks++; if (if_rr.ramREN !== 1'b0) begin failures++; $display("FAIL abort_idle ramREN got=%b exp=0", if_rr.ramREN); end
    tick();
    #1;
    checks++; if (if_rr.ramaddr !== 32'h300) begin failures++; $display("FAIL abort_ptr addr got=%h exp=300", if_rr.ramaddr); end
    clear_inputs();
  endtask

  task automatic test_error();
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h400;
    tick();
    ramstate = ERROR;
    #1;
    checks++; if (if_rr.ramerr !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", if_rr.ramerr); end
    checks++; if (if_rr.iwait !== 2'b10 || if_rr.ramREN !== 1'b1) begin failures++; $display("FAIL err_wait iwait=%b REN=%b exp 10/1", if_rr.iwait, if_rr.ramREN); end
    tick();
    ramstate = FREE; iREN = 2'b11; iaddr[1] = 32'h410;
    #1;
    checks++; if (if_rr.ramerr !== 1'b0 || if_rr.iwait !== 2'b11) begin failures++; $display("FAIL err_after ramerr=%b iwait=%b exp 0/11", if_rr.ramerr, if_rr.iwait); end
    tick();
    #1;
    checks++; if (if_rr.ramaddr !== 32'h410) begin failures++; $display("FAIL err_ptr addr got=%h exp=410", if_rr.ramaddr); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    dREN = 2'b11; iREN = 2'b11;
    daddr[0] = 32'hA0; iaddr[0] = 32'hB0; daddr[1] = 32'hC0; iaddr[1] = 32'hD0;
    tick();
    ramstate = ACCESS;
    tick();
    ramstate = BUSY;
    tick();
    #1;
    checks++; if (if_df.ramREN !== 1'b1 || if_df.ramaddr !== 32'hC0) begin failures++; $display("FAIL arst_pre REN=%b addr=%h exp 1/c0", if_df.ramREN, if_df.ramaddr); end
    #2;
    RST = 1'b1;
    ramstate = ERROR;
    #1;
    checks++; if (if_df.ramREN !== 1'b0 || if_df.ramWEN !== 1'b0 || if_df.ramaddr !== 32'h0) begin failures++; $display("FAIL arst_en REN=%b WEN=%b addr=%h exp 0/0/0", if_df.ramREN, if_df.ramWEN, if_df.ramaddr); end
    checks++; if (if_df.ramerr !== 1'b0 || if_df.dwait !== 2'b11) begin failures++; $display("FAIL arst_err ramerr=%b dwait=%b exp 0/11", if_df.ramerr, if_df.dwait); end
    tick();
    RST = 1'b0;
    ramstate = FREE;
    tick();
    #1;
    checks++; if (if_df.ramaddr !== 32'hA0) begin failures++; $display("FAIL arst_df_first addr got=%h exp=a0", if_df.ramaddr); end
    checks++; if (if_rr.ramaddr !== 32'hA0) begin failures++; $display("FAIL arst_rr_first addr got=%h exp=a0", if_rr.ramaddr); end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_data_first();
    test_round_robin();
    test_abort();
    test_error();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of CPUs served (1..8).
REQ-002 SHALL have parameter DATA_FIRST, default 1; 1 = data requests beat instruction requests, 0 = pure round-robin.
REQ-003 SHALL have port CLK  input  1  system clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port iREN  input  CPUS  instruction read request per CPU.
REQ-006 SHALL have port dREN  input  CPUS  data read request per CPU.
REQ-007 SHALL have port dWEN  input  CPUS  data write request per CPU.
REQ-008 SHALL have port iaddr  input  CPUS x 32  instruction address per CPU.
REQ-009 SHALL have port daddr  input  CPUS x 32  data address per CPU.
REQ-010 SHALL have port dstore  input  CPUS x 32  write data per CPU.
REQ-011 SHALL have port iwait  output  CPUS  instruction stall per CPU.
REQ-012 SHALL have port dwait  output  CPUS  data stall per CPU.
REQ-013 SHALL have ports iload and dload  output  CPUS x 32  read data per CPU.
REQ-014 SHALL have ports ramREN, ramWEN  output  1  RAM enables.
REQ-015 SHALL have ports ramaddr, ramstore  output  32  RAM address and write data.
REQ-016 SHALL have port ramload  input  32  RAM read data.
REQ-017 SHALL have port ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-018 SHALL have port ramerr  output  1  one-cycle pulse on ERROR completion.

Function
REQ-020 SHALL number requesters k = 2*cpu + 0 (data) and 2*cpu + 1 (instr); 2*CPUS requesters.
REQ-021 Requester active: data = dREN|dWEN, instr = iREN.
REQ-022 FSM states: IDLE, XFER.
REQ-023 IDLE: no request -> stay; ram enables 0, all waits 1.
REQ-024 IDLE: any request -> latch winner index, go XFER next cycle; no RAM access in the arbitration cycle.
REQ-025 Winner = first active requester at or after rr_ptr, modulo 2*CPUS.
REQ-026 DATA_FIRST=1: if any data requester is active, only data requesters are eligible.
REQ-027 XFER: ramaddr/ramstore/enables come from the winner only; dWEN wins over dREN (ramWEN=1, ramREN=0).
REQ-028 XFER, ramstate ACCESS: winner's wait = 0 for that cycle; rr_ptr <= winner+1 (wraps); -> IDLE.
REQ-029 XFER, ramstate ERROR: same as ACCESS, plus ramerr = 1 for that cycle.
REQ-030 XFER, ramstate FREE or BUSY: stay; all waits 1.
REQ-031 XFER, winner request drops: abort; enables 0 same cycle; -> IDLE; rr_ptr unchanged.
REQ-032 Non-winner waits stay 1 at all times.
REQ-033 iload and dload of every CPU SHALL equal ramload combinationally.
REQ-034 Bounded latency: a held request completes within 2*CPUS grants.
REQ-035 Requests arriving during XFER are seen only in the next IDLE cycle.

Reset
REQ-040 RST asserted SHALL force IDLE, rr_ptr = 0, winner = 0 immediately (asynchronous).
REQ-041 Outputs under reset: ramREN = ramWEN = 0, ramaddr = ramstore = 0, all waits 1, ramerr = 0.
REQ-042 Reset during XFER SHALL abort with no completion pulse; first grant after release uses rr_ptr = 0.

Structure
REQ-050 ramstate_t and word_t SHALL come from cpu_types_pkg; the FSM state enum SHALL be placed there as arb_state_t.
REQ-051 The round-robin priority picker SHALL be one combinational sub-module, rr_picker, parametrised by requester count.

Verification
REQ-060 CPUS=2; CPU0 iREN, iaddr=0x100, ACCESS on 2nd XFER cycle -> ramREN=1, ramaddr=0x100, iwait[0]=0 for exactly that cycle.
REQ-061 DATA_FIRST=1; CPU0 iREN and CPU1 dWEN, daddr=0x200, dstore=0xDEADBEEF together -> CPU1 served first with ramWEN=1, ramstore=0xDEADBEEF; CPU0 next.
REQ-062 DATA_FIRST=0; all 4 requesters held, ACCESS after 1 BUSY cycle each -> grant order k=0,1,2,3,0.
REQ-063 Winner drops dREN mid-BUSY -> ramREN=0 same cycle, IDLE next cycle, rr_ptr unchanged, no wait pulse.
REQ-064 ramstate=ERROR in XFER -> ramerr=1 and winner wait=0 for one cycle; rr_ptr advances.
REQ-065 RST asserted mid-XFER between clock edges -> enables 0 before next edge; after release CPU0 data wins a full contention.
